sprite_line_eval: RTL and testbench
===================================

# sprite_line_eval

Per-scanline sprite evaluator. It scans a SPRITE_NUM-entry sprite attribute RAM once per `line_start` and selects up to SLOT_NUM sprites that intersect the requested line, lowest index first. Selected sprites are written into a draw-slot register file. This block replaces the fixed six-channel, hard-indexed tile-draw arrangement in the PPU with a generic front end. It runs in the 100 MHz pixel-compute domain and reads the sprite RAM's second read port.

## Interface
Parameters:
- SPRITE_NUM, 64, entries in sprite RAM (power of 2).
- SLOT_NUM, 8, draw slots per line (1..SPRITE_NUM).
- SPRITE_H, 16, sprite height in lines (power of 2).
- POS_W, 10, coordinate width.

Sprite word: [9:0] x, [19:10] y, [27:20] tile, [28] enable, [31:29] palette. x and y are POS_W bits.

Ports:
- clk  in  1  compute clock (100 MHz).
- rstn  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse; begin evaluation of line_y.
- line_y  in  POS_W  line to evaluate; sampled on line_start.
- ram_addr  out  $clog2(SPRITE_NUM)  sprite RAM read address.
- ram_rdata  in  32  sprite word; valid one cycle after ram_addr.
- busy  out  1  evaluation in progress.
- slot_wr  out  1  slot write strobe.
- slot_idx  out  $clog2(SLOT_NUM)  slot being written.
- slot_sprite  out  $clog2(SPRITE_NUM)  sprite index of the written slot.
- slot_row  out  $clog2(SPRITE_H)  row within sprite (line_y − y).
- slot_data  out  32  raw sprite word.
- slot_count  out  $clog2(SLOT_NUM)+1  slots filled so far this line.
- overflow  out  1  more than SLOT_NUM hits on this line.
- eval_done  out  1  one-cycle pulse; results final.

## Operation
- FSM states: IDLE, SCAN, FLUSH, DONE.
- IDLE: on line_start, latch line_y, clear slot_count and overflow, set ram_addr=0, go to SCAN.
- SCAN: increment ram_addr each cycle. Move to FLUSH after issuing address SPRITE_NUM−1.
- Read pipeline: address k is issued in cycle k+1. Data arrives in cycle k+2 and is registered. The hit test result drives slot_wr in cycle k+3.
- Hit test: enable=1 AND line_y ≥ y AND (line_y − y) < SPRITE_H. The comparison is computed in POS_W+1 bits, so y near 2^POS_W never wraps onto low lines.
- On a hit with slot_count < SLOT_NUM:
  - slot_wr=1, slot_idx=slot_count, slot_sprite=k, slot_row=(line_y−y)[log2 SPRITE_H−1:0], slot_data=word.
  - slot_count increments.
- On a hit with slot_count = SLOT_NUM: behaviour is set by the macro (see Configuration).
- FLUSH: drain in-flight reads. Go to DONE after the last check.
- DONE: pulse eval_done for one cycle, then return to IDLE.
- line_start while busy: abort, restart from address 0 with the new line_y, clear slot_count and overflow. No eval_done is issued for the aborted line. In-flight reads from the aborted scan are discarded.
- line_start in the DONE cycle is accepted as a new start.
- Reset: every output is 0 and the FSM goes to IDLE. Reset mid-scan leaves no residual slot_wr.

## Timing
- line_start in cycle 0 → busy=1 and ram_addr=0 in cycle 1.
- Full scan: last slot_wr possible in cycle SPRITE_NUM+2; eval_done in cycle SPRITE_NUM+3 (last busy cycle); busy=0 from SPRITE_NUM+4.
- slot_count and overflow are stable from eval_done until the next line_start.
- Throughput: one sprite per cycle. SPRITE_NUM=64 gives 67 cycles, well inside an 800-pixel line at 25.2 MHz (~3175 cycles at 100 MHz).

## Configuration
- SPRITE_OVERFLOW_SCAN_EN defined:
  - Scan always covers all SPRITE_NUM entries.
  - The first hit beyond SLOT_NUM sets overflow=1 (sticky for the line) and is not written.
- Undefined:
  - The scan terminates early once slot_count reaches SLOT_NUM; remaining in-flight reads are discarded.
  - eval_done pulses the cycle after the SLOT_NUM-th slot_wr.
  - overflow is tied to 0.

## Test plan
- Reset: assert rstn=0 mid-scan → all outputs 0 immediately; after release, busy=0 and no slot_wr.
- Two hits: sprite 3 y=100, sprite 10 y=95, all others disabled, line_y=105 →
  - cycle 6: slot 0, sprite 3, row 5.
  - cycle 13: slot 1, sprite 10, row 10.
  - eval_done in cycle 67, slot_count=2, overflow=0.
- Boundaries: sprite y=100 → line 115 hits with row 15; lines 116 and 99 miss. Sprite y=1020 with line_y=4 → miss (no wrap).
- Overflow: sprites 0..9 all y=50, line_y=50:
  - With macro: slots 0..7 hold sprites 0..7, overflow=1, eval_done in cycle 67.
  - Without macro: 8th slot_wr in cycle 10, eval_done in cycle 11, overflow=0.
- Restart: line_start at cycle 0, again at cycle 20 with a new line_y → ram_addr=0 in cycle 21, slot_count=0, exactly one eval_done (cycle 87).
- Disabled sprite: enable=0 with y matching the line → no slot_wr.

Source files
------------

// File: rtl/sprite_line_eval.sv
// sprite_line_eval: per-scanline sprite evaluator.
//
// Walks the sprite attribute RAM once per line_start, lowest index first,
// and writes every sprite that covers the requested line into the next free
// draw slot, up to SLOT_NUM slots.
//
// Optional feature macro: SPRITE_OVERFLOW_SCAN_EN
//   defined   - the scan always covers every entry; the first hit that finds
//               no free slot raises a sticky overflow flag for the line.
//   undefined - the scan stops as soon as the last slot is written and
//               overflow is tied to 0.
//
// Read pipeline for sprite k (cycle 0 = line_start cycle):
//   cycle k+1  address k on ram_addr
//   cycle k+2  ram_rdata holds word k, captured into word_q
//   cycle k+3  hit test on word_q drives slot_wr
//
// Handshake: there is no back-pressure anywhere. line_start is a one-cycle
// request that is always accepted (it restarts a scan in progress),
// slot_wr is a one-cycle strobe the slot file must take in the same cycle,
// and eval_done is a one-cycle pulse after which slot_count/overflow hold
// until the next line_start.
module sprite_line_eval #(
    parameter int SPRITE_NUM = 64,
    parameter int SLOT_NUM   = 8,
    parameter int SPRITE_H   = 16,
    parameter int POS_W      = 10,
    localparam int ADDR_W    = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1,
    localparam int IDX_W     = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1,
    localparam int ROW_W     = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
    localparam int CNT_W     = $clog2(SLOT_NUM) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              line_start,
    input  logic [POS_W-1:0]  line_y,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              slot_wr,
    output logic [IDX_W-1:0]  slot_idx,
    output logic [ADDR_W-1:0] slot_sprite,
    output logic [ROW_W-1:0]  slot_row,
    output logic [31:0]       slot_data,
    output logic [CNT_W-1:0]  slot_count,
    output logic              overflow,
    output logic              eval_done,
    output logic [1:0]        dbg_state
);

    localparam int EN_BIT = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Scan address and the line under evaluation.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [POS_W-1:0]  line_q, line_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Stage 1: a read was issued last cycle, its data is on ram_rdata now.
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;

    // Stage 2: captured sprite word being hit-tested this cycle.
    logic              chk_vld_q, chk_vld_d;
    logic [ADDR_W-1:0] chk_idx_q;
    logic [31:0]       word_q;

    // Pipeline kill: restart or early stop throws away in-flight reads.
    logic              kill_pipe;

    // Hit test signals.
    logic [POS_W-1:0]  spr_y;
    logic [POS_W:0]    diff;
    logic              hit_c;
    logic              slot_free_c;
    logic              slot_wr_c;

    // Hit test in POS_W+1 bits: a sprite near the bottom of the coordinate
    // space gives a negative difference (top bit set) instead of wrapping
    // around onto the low lines.
    assign spr_y       = word_q[POS_W +: POS_W];
    assign diff        = {1'b0, line_q} - {1'b0, spr_y};
    assign hit_c       = word_q[EN_BIT] && !diff[POS_W]
                         && (diff < (POS_W+1)'(SPRITE_H));
    assign slot_free_c = (count_q < CNT_W'(SLOT_NUM));
    // A fresh line_start abandons the old line, so a check landing in that
    // same cycle belongs to stale data and must not be written.
    assign slot_wr_c   = chk_vld_q && hit_c && slot_free_c && !line_start;

    // Next-state, address walk, slot counting and pipeline control.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        line_d    = line_q;
        count_d   = count_q;
        rd_pend_d = 1'b0;
        rd_idx_d  = rd_idx_q;
        kill_pipe = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SCAN: begin
                rd_pend_d = 1'b1;
                rd_idx_d  = addr_q;
                addr_d    = addr_q + ADDR_W'(1);
                if (addr_q == ADDR_W'(SPRITE_NUM - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Once nothing is outstanding in stage 1, this cycle holds
                // the final check of the line.
                if (!rd_pend_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (slot_wr_c) begin
            count_d = count_q + CNT_W'(1);
        end

`ifndef SPRITE_OVERFLOW_SCAN_EN
        // Last free slot just got written: nothing more can be stored, so
        // stop scanning and drop whatever reads are still in flight.
        if (slot_wr_c && (count_q == CNT_W'(SLOT_NUM - 1))) begin
            state_d   = DONE;
            addr_d    = '0;
            rd_pend_d = 1'b0;
            kill_pipe = 1'b1;
        end
`endif

        // line_start wins over everything, including a DONE cycle.
        if (line_start) begin
            state_d   = SCAN;
            addr_d    = '0;
            line_d    = line_y;
            count_d   = '0;
            rd_pend_d = 1'b0;
            kill_pipe = 1'b1;
        end

        chk_vld_d = rd_pend_q && !kill_pipe;
    end

    // State, address, line and slot counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            count_q <= count_d;
        end
    end

    // Read pipeline: stage 1 tracks the issued address, stage 2 captures
    // the returned word together with its sprite index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            chk_vld_q <= 1'b0;
            chk_idx_q <= '0;
            word_q    <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            chk_vld_q <= chk_vld_d;
            if (rd_pend_q) begin
                word_q    <= ram_rdata;
                chk_idx_q <= rd_idx_q;
            end
        end
    end

`ifdef SPRITE_OVERFLOW_SCAN_EN
    logic ovf_q, ovf_d;

    // Overflow flag: set by the first hit that finds every slot taken,
    // held for the rest of the line, cleared by the next line_start.
    always_comb begin
        ovf_d = ovf_q;
        if (chk_vld_q && hit_c && !slot_free_c) begin
            ovf_d = 1'b1;
        end
        if (line_start) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign ram_addr    = addr_q;
    assign busy        = (state_q != IDLE);
    assign eval_done   = (state_q == DONE);
    assign slot_wr     = slot_wr_c;
    assign slot_idx    = count_q[IDX_W-1:0];
    assign slot_sprite = chk_idx_q;
    assign slot_row    = diff[ROW_W-1:0];
    assign slot_data   = word_q;
    assign slot_count  = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sprite_line_eval.sv
// Testbench for sprite_line_eval: behavioural sprite RAM, a slot-write
// scoreboard fed by an independent integer model, and directed plus random
// line evaluations. Expectations follow SPRITE_OVERFLOW_SCAN_EN when defined.
module tb_sprite_line_eval;

    localparam int SPRITE_NUM = 64;
    localparam int SLOT_NUM   = 8;
    localparam int SPRITE_H   = 16;
    localparam int POS_W      = 10;
    localparam int EW         = 77;  // {cycle32, idx3, sprite6, row4, data32}

    logic        clk = 1'b0;
    logic        rstn;
    logic        line_start;
    logic [9:0]  line_y;
    logic [5:0]  ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        busy;
    logic        slot_wr;
    logic [2:0]  slot_idx;
    logic [5:0]  slot_sprite;
    logic [3:0]  slot_row;
    logic [31:0] slot_data;
    logic [3:0]  slot_count;
    logic        overflow;
    logic        eval_done;
    logic [1:0]  dbg_state;

    logic [31:0]   mem [SPRITE_NUM];
    logic [EW-1:0] exp_q [$];

    int cyc = 0;
    int t0 = 0;
    int n_pass = 0;
    int n_checks = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    sprite_line_eval #(
        .SPRITE_NUM(SPRITE_NUM),
        .SLOT_NUM  (SLOT_NUM),
        .SPRITE_H  (SPRITE_H),
        .POS_W     (POS_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .line_start (line_start),
        .line_y     (line_y),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .slot_wr    (slot_wr),
        .slot_idx   (slot_idx),
        .slot_sprite(slot_sprite),
        .slot_row   (slot_row),
        .slot_data  (slot_data),
        .slot_count (slot_count),
        .overflow   (overflow),
        .eval_done  (eval_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read sprite RAM: data one cycle after the address.
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard monitor: pop one expected write per slot_wr, count eval_done.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rstn === 1'b1) begin
            if (slot_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 64'(slot_sprite), 64'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cycle",  64'(cyc),         64'(e[76:45]));
                    check("wr_idx",    64'(slot_idx),    64'(e[44:42]));
                    check("wr_sprite", 64'(slot_sprite), 64'(e[41:36]));
                    check("wr_row",    64'(slot_row),    64'(e[35:32]));
                    check("wr_data",   64'(slot_data),   64'(e[31:0]));
                end
            end
            if (eval_done === 1'b1) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [31:0] make_word(input bit en, input int y);
        logic [2:0] pal  = 3'($urandom_range(0, 7));
        logic [7:0] tile = 8'($urandom_range(0, 255));
        logic [9:0] x    = 10'($urandom_range(0, 1023));
        logic [9:0] yy   = y[9:0];
        return {pal, en, tile, yy, x};
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < SPRITE_NUM; k++) mem[k] = make_word(1'b0, $urandom_range(0, 1023));
    endtask

    // Pulse line_start in the first cycle at or after 'target', then check
    // the first scan cycle.
    task automatic start(input int line, input int target);
        @(posedge clk); #1;
        while (cyc < target) begin @(posedge clk); #1; end
        line_y = line[9:0];
        line_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        line_start = 1'b0;
        @(negedge clk);
        check("busy_c1",  64'(busy),       64'd1);
        check("addr_c1",  64'(ram_addr),   64'd0);
        check("count_c1", 64'(slot_count), 64'd0);
    endtask

    // Reference model: pushes expected writes occurring before t_start+cutoff.
    task automatic model(input int line, input int t_start, input int cutoff,
                         output int done_exp, output int cnt, output bit ovf);
        int yi, wr;
        logic [31:0] w;
        cnt = 0;
        ovf = 1'b0;
        done_exp = t_start + SPRITE_NUM + 3;
        for (int k = 0; k < SPRITE_NUM; k++) begin
            w  = mem[k];
            yi = int'(w[19:10]);
            if (w[28] && line >= yi && (line - yi) < SPRITE_H) begin
                if (cnt < SLOT_NUM) begin
                    wr = t_start + k + 3;
                    if (k + 3 < cutoff)
                        exp_q.push_back({32'(wr), 3'(cnt), 6'(k), 4'(line - yi), w});
                    cnt++;
`ifndef SPRITE_OVERFLOW_SCAN_EN
                    if (cnt == SLOT_NUM) begin
                        done_exp = wr + 1;
                        break;
                    end
`endif
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    endtask

    // Wait for eval_done (bounded), then check the line's final results.
    task automatic finish_line(input string tag, input int d0, input int done_exp,
                               input int cnt, input bit ovf);
        int limit = t0 + 200;
        while (done_cnt == d0 && cyc < limit) @(posedge clk);
        if (done_cnt == d0) check({tag, "_done_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        check({tag, "_done_cyc"}, 64'(done_cyc),   64'(done_exp));
        check({tag, "_count"},    64'(slot_count), 64'(cnt));
        check({tag, "_ovf"},      64'(overflow),   64'(ovf));
        check({tag, "_idle"},     64'(busy),       64'd0);
        check({tag, "_q_empty"},  64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, "_one_done"}, 64'(done_cnt),   64'(d0 + 1));
    endtask

    task automatic run_line(input string tag, input int line);
        int d0, de, c;
        bit o;
        d0 = done_cnt;
        start(line, 0);
        model(line, t0, 100000, de, c, o);
        finish_line(tag, d0, de, c, o);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0, de, c, ta;
        bit o;
        rstn = 1'b0;
        line_start = 1'b0;
        line_y = '0;
        clear_mem();

        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_wr",    64'(slot_wr),    64'd0);
        check("rst_done",  64'(eval_done),  64'd0);
        check("rst_addr",  64'(ram_addr),   64'd0);
        check("rst_count", 64'(slot_count), 64'd0);
        check("rst_ovf",   64'(overflow),   64'd0);
        check("rst_state", 64'(dbg_state),  64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Two hits: sprite 3 (y=100) row 5, sprite 10 (y=95) row 10.
        mem[3]  = make_word(1'b1, 100);
        mem[10] = make_word(1'b1, 95);
        run_line("two_hits", 105);

        // Vertical boundaries and no wrap near the top of the coordinate space.
        clear_mem();
        mem[5] = make_word(1'b1, 100);
        run_line("y100_l115", 115);
        run_line("y100_l116", 116);
        run_line("y100_l99",  99);
        mem[5] = make_word(1'b1, 1020);
        run_line("y1020_l4",    4);
        run_line("y1020_l1023", 1023);

        // Disabled sprite sitting exactly on the line.
        clear_mem();
        mem[7] = make_word(1'b0, 200);
        run_line("disabled", 200);

        // More hits than slots.
        clear_mem();
        for (int k = 0; k < 10; k++) mem[k] = make_word(1'b1, 50);
        run_line("overflow", 50);

        // Random sprite tables.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < SPRITE_NUM; k++)
                mem[k] = make_word($urandom_range(0, 3) == 0, $urandom_range(0, 60));
            run_line("random", $urandom_range(0, 75));
        end

        // Restart mid-scan: only the second line completes.
        clear_mem();
        mem[3]  = make_word(1'b1, 100);
        mem[10] = make_word(1'b1, 95);
        d0 = done_cnt;
        start(105, 0);
        ta = t0;
        model(105, t0, 20, de, c, o);
        start(115, ta + 20);
        check("restart_cycle", 64'(t0 - ta), 64'd20);
        model(115, t0, 100000, de, c, o);
        finish_line("restart", d0, de, c, o);

        // Reset in the middle of a scan.
        d0 = done_cnt;
        start(105, 0);
        model(105, t0, 8, de, c, o);
        while (cyc < t0 + 8) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        check("mrst_busy",   64'(busy),        64'd0);
        check("mrst_wr",     64'(slot_wr),     64'd0);
        check("mrst_done",   64'(eval_done),   64'd0);
        check("mrst_addr",   64'(ram_addr),    64'd0);
        check("mrst_count",  64'(slot_count),  64'd0);
        check("mrst_ovf",    64'(overflow),    64'd0);
        check("mrst_idx",    64'(slot_idx),    64'd0);
        check("mrst_sprite", 64'(slot_sprite), 64'd0);
        check("mrst_row",    64'(slot_row),    64'd0);
        check("mrst_data",   64'(slot_data),   64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (80) @(negedge clk);
        check("mrst_idle",    64'(busy),          64'd0);
        check("mrst_no_done", 64'(done_cnt),      64'(d0));
        check("mrst_q_empty", 64'(exp_q.size()),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
